// File: rtl/pin_byte_rx.sv
// rtl/pin_byte_rx.sv - strobe-clocked serial byte receiver with handshake output and match counter
// Bits arrive MSB first on rising strobe edges; a gap longer than TIMEOUT abandons a partial frame.
module pin_byte_rx #(
  parameter logic [7:0] EXPECT  = 8'h50,
  parameter int         TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sdata_i,
  input  logic       sstrb_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       match_o,
  output logic [7:0] match_cnt_o,
  output logic       overrun_o,
  output logic       timeout_o
);

  localparam logic [7:0] TMO_LIMIT = TIMEOUT[7:0];

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state, state_d;
  logic       data_s1, data_s2;
  logic       strb_s1, strb_s2, strb_s3;
  logic [1:0] inh_cnt;
  logic [6:0] sreg;
  logic [3:0] bit_cnt;
  logic [7:0] idle_cnt;
  logic [7:0] new_byte;
  logic       strb_edge;
  logic       shift_first, shift_next, byte_done, tmo_hit;
  logic       idle_inc, idle_clr;
  logic       xfer, load_byte;

  // Edges are masked until the synchronizer has settled after reset, so a
  // strobe held high across reset release does not look like a fresh edge.
  assign strb_edge = strb_s2 & ~strb_s3 & (inh_cnt == 2'd3);
  assign new_byte  = {sreg, data_s2};
  assign xfer      = valid_o & ready_i;
  assign load_byte = byte_done & (~valid_o | ready_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d     = state;
    shift_first = 1'b0;
    shift_next  = 1'b0;
    byte_done   = 1'b0;
    tmo_hit     = 1'b0;
    idle_inc    = 1'b0;
    idle_clr    = 1'b0;
    case (state)
      IDLE: begin
        idle_clr = 1'b1;
        if (strb_edge) begin
          shift_first = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        // A strobe edge arriving in the timeout cycle still counts.
        if (strb_edge) begin
          shift_next = 1'b1;
          idle_clr   = 1'b1;
          if (bit_cnt == 4'd7) begin
            byte_done = 1'b1;
            state_d   = DONE;
          end
        end else if (idle_cnt == TMO_LIMIT) begin
          tmo_hit  = 1'b1;
          idle_clr = 1'b1;
          state_d  = IDLE;
        end else begin
          idle_inc = 1'b1;
        end
      end
      DONE: begin
        idle_clr = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_s1     <= 1'b0;
      data_s2     <= 1'b0;
      strb_s1     <= 1'b0;
      strb_s2     <= 1'b0;
      strb_s3     <= 1'b0;
      inh_cnt     <= 2'd0;
      sreg        <= 7'd0;
      bit_cnt     <= 4'd0;
      idle_cnt    <= 8'd0;
      byte_o      <= 8'h00;
      valid_o     <= 1'b0;
      match_o     <= 1'b0;
      match_cnt_o <= 8'd0;
      overrun_o   <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      data_s1 <= sdata_i;
      data_s2 <= data_s1;
      strb_s1 <= sstrb_i;
      strb_s2 <= strb_s1;
      strb_s3 <= strb_s2;
      if (inh_cnt != 2'd3) begin
        inh_cnt <= inh_cnt + 2'd1;
      end

      timeout_o <= tmo_hit;

      if (idle_clr) begin
        idle_cnt <= 8'd0;
      end else if (idle_inc) begin
        idle_cnt <= idle_cnt + 8'd1;
      end

      // Only the low seven bits are kept; the eighth bit goes straight to byte_o.
      if (shift_first) begin
        sreg    <= {6'd0, data_s2};
        bit_cnt <= 4'd1;
      end else if (shift_next) begin
        sreg    <= new_byte[6:0];
        bit_cnt <= bit_cnt + 4'd1;
      end else if (tmo_hit || state == DONE) begin
        bit_cnt <= 4'd0;
      end

      if (xfer && match_o && match_cnt_o != 8'hFF) begin
        match_cnt_o <= match_cnt_o + 8'd1;
      end

      if (load_byte) begin
        byte_o  <= new_byte;
        valid_o <= 1'b1;
        match_o <= (new_byte == EXPECT);
      end else if (xfer) begin
        valid_o <= 1'b0;
        match_o <= 1'b0;
      end

      if (byte_done && valid_o && !ready_i) begin
        overrun_o <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pin_byte_rx.md
PIN_BYTE_RX -- requirements
Module: pin_byte_rx

Interface
REQ-001 Parameter EXPECT, default 8'h50: reference byte that received bytes are compared against.
REQ-002 Parameter TIMEOUT, default 255: maximum clk cycles allowed between strobe edges inside a frame (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sdata_i  input  1  serial data pin, asynchronous to clk.
REQ-006 sstrb_i  input  1  serial strobe pin, asynchronous to clk; the data bit is valid on its rising edge.
REQ-007 byte_o  output  8  last completed byte.
REQ-008 valid_o  output  1  byte_o holds an unconsumed byte.
REQ-009 ready_i  input  1  consumer accepts byte_o.
REQ-010 match_o  output  1  byte_o == EXPECT; qualified by valid_o.
REQ-011 match_cnt_o  output  8  count of accepted bytes that matched EXPECT.
REQ-012 overrun_o  output  1  sticky flag: a completed byte was dropped.
REQ-013 timeout_o  output  1  one-cycle pulse: a partial frame was discarded.

Function
REQ-014 sdata_i and sstrb_i SHALL each pass through a 2-flop synchronizer of equal depth, so data and strobe stay aligned.
REQ-015 A strobe edge SHALL be synchronized-strobe high in the current cycle and low in the previous cycle (third flop).
REQ-016 Each strobe edge SHALL shift the synchronized data bit into an 8-bit shift register, MSB first.
REQ-017 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-018 In IDLE, the first strobe edge SHALL capture bit 7, set bit count to 1, and move to SHIFT.
REQ-019 In SHIFT, each strobe edge SHALL increment bit count; the 8th edge SHALL move to DONE.
REQ-020 Latency: if sstrb_i is first sampled high for bit 0 at edge t, byte_o/valid_o/match_o SHALL update at edge t+2.
REQ-021 In DONE (one cycle), the FSM SHALL return to IDLE; the byte SHALL be loaded into byte_o only if valid_o=0 or a handshake occurs in the same cycle.
REQ-022 Handshake: a transfer SHALL occur on a clk edge with valid_o=1 and ready_i=1; valid_o SHALL clear on the next cycle unless a new byte loads on the same edge, in which case valid_o stays 1 with the new byte.
REQ-023 A byte completed while valid_o=1 and ready_i=0 SHALL be dropped; overrun_o SHALL set, and byte_o/valid_o SHALL remain unchanged.
REQ-024 byte_o and match_o SHALL hold stable while valid_o=1 and ready_i=0.
REQ-025 match_cnt_o SHALL increment on each transfer with match_o=1 and saturate at 255 (no wrap).
REQ-026 In SHIFT, an 8-bit idle counter SHALL clear on each strobe edge and increment otherwise.
REQ-027 When the idle counter reaches TIMEOUT, the FSM SHALL discard the partial byte, pulse timeout_o for 1 cycle, and return to IDLE; a strobe edge in that same cycle SHALL win (counted, no timeout).
REQ-028 In IDLE and DONE, timeout SHALL not apply.
REQ-029 overrun_o SHALL clear only by rst.

Reset
REQ-030 While rst=1 at a clk edge: FSM=IDLE; bit count=0; idle counter=0; synchronizer flops=0.
REQ-031 While rst=1 at a clk edge: byte_o=8'h00, valid_o=0, match_o=0, match_cnt_o=0, overrun_o=0, timeout_o=0.
REQ-032 Strobe edge detection SHALL be inhibited for the first 3 cycles after rst deasserts, so a strobe held high across reset is not counted.
REQ-033 Reset mid-frame or with valid_o=1 SHALL abandon all state; the next frame starts at bit 7.

Verification
REQ-034 Send 0x50 (8 strobes, 4 clk high/4 low each), ready_i=1 -> byte_o=0x50, valid_o for 1 cycle, match_o=1, match_cnt_o=1.
REQ-035 Send 0xA3 then 0x11 with ready_i=0, then raise ready_i -> byte_o=0xA3, overrun_o=1, match_cnt_o=0; valid_o clears after the transfer.
REQ-036 Send 3 bits, then idle for 255 cycles -> timeout_o pulses once; the next 8 bits of 0x50 yield byte_o=0x50.
REQ-037 Send 256 frames of 0x50, ready_i=1 -> match_cnt_o=255 (saturated).
REQ-038 Assert rst after 5 bits with sstrb_i held high through reset release -> no edge counted; a following 0x50 frame yields byte_o=0x50.
REQ-039 Complete a byte on the same edge as a transfer of the previous byte -> valid_o stays 1, byte_o takes the new value, overrun_o=0.
